// File: rtl/add_digit_serial.sv
// -----------------------------------------------------------------------------
// add_digit_serial
//   Multi-cycle digit-serial binary adder: S = A + B + CI, computed `digit`
//   bits per cycle, least-significant digit first. A word takes
//   n = width/digit compute cycles. An operand port and a result port sit on
//   either side of the adder.
//
//   Handshake: a transfer happens on a rising clk_i edge where valid and ready
//   are both high. The producer holds valid until that edge. The ready side
//   never depends combinationally on valid. in_ready_o is high only in IDLE.
//   out_valid_o is high only in DONE, and S/CO/V are held stable while it is
//   high.
//
// Parameters
//   width  operand/result word width (>= 1)
//   digit  bits added per cycle (1..width, must divide width)
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operands A, B, CI valid
//   in_ready_o   block can accept operands (IDLE)
//   A, B         operands (unsigned or two's complement)
//   CI           carry in
//   out_valid_o  S, CO, V valid (DONE)
//   out_ready_i  consumer accepts result
//   S            registered sum bits
//   CO           carry out of bit width-1
//   V            two's-complement overflow (carry into MSB xor CO)
//   dbg_state_o  current FSM state, for observation only
// -----------------------------------------------------------------------------
module add_digit_serial #(
  parameter int width = 8,
  parameter int digit = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] S,
  output logic             CO,
  output logic             V,
  output logic [1:0]       dbg_state_o
);

  localparam int n     = width / digit;
  localparam int cnt_w = (n > 1) ? $clog2(n) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n - 1);

  if (digit < 1 || digit > width || (width % digit) != 0) begin : g_bad_params
    $error("add_digit_serial: digit must be in 1..width and divide width");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [width-1:0]   a_q;
  logic [width-1:0]   b_q;
  logic               carry_q;
  logic [cnt_w-1:0]   cnt_q;

  logic [digit-1:0]   a_d;
  logic [digit-1:0]   b_d;
  logic [digit:0]     d_full;
  logic [digit-1:0]   d_sum;
  logic               d_co;
  logic               d_c_msb;
  logic               last;

  // One digit of ripple addition on the current slice of the captured operands.
  always_comb begin
    a_d     = a_q[int'(cnt_q)*digit +: digit];
    b_d     = b_q[int'(cnt_q)*digit +: digit];
    d_full  = {1'b0, a_d} + {1'b0, b_d} + {{digit{1'b0}}, carry_q};
    d_sum   = d_full[digit-1:0];
    d_co    = d_full[digit];
    // The carry into the top bit of the digit is recovered from the sum bit.
    // In the last digit this is the carry into bit width-1.
    d_c_msb = d_sum[digit-1] ^ a_d[digit-1] ^ b_d[digit-1];
    last    = (cnt_q == last_cnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      CO      <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CI;
            cnt_q   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Write only the digit just computed. Higher digits keep their old
          // value until their turn comes.
          S[int'(cnt_q)*digit +: digit] <= d_sum;
          carry_q <= d_co;
          if (last) begin
            CO    <= d_co;
            V     <= d_c_msb ^ d_co;
            cnt_q <= '0;
            state <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_add_digit_serial.sv
module tb_add_digit_serial;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
  logic         v;
  logic [1:0]   dbg;

  int n_cmp = 0;
  int n_err = 0;
  int sw_done_cnt = 0;

  add_digit_serial #(.width(W), .digit(D)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .A           (a),
    .B           (b),
    .CI          (ci),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .S           (s),
    .CO          (co),
    .V           (v),
    .dbg_state_o (dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result as {co, v, s}.
  function automatic logic [9:0] model8(input logic [7:0] ma, input logic [7:0] mb, input logic mci);
    int u;
    int sg;
    logic [7:0] ms;
    u  = int'(ma) + int'(mb) + int'(mci);
    sg = int'($signed(ma)) + int'($signed(mb)) + int'(mci);
    ms = u[7:0];
    return {(u > 255), (sg > 127 || sg < -128), ms};
  endfunction

  // Runs one operation. Must be called with the DUT idle.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ici, input int stall,
                        output logic [7:0] os, output logic oco, output logic ov,
                        output int lat, output bit busy_ok);
    in_valid = 1'b1; a = ia; b = ib; ci = ici;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < 50) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    repeat (stall) begin @(posedge clk); #1; end
    os = s; oco = co; ov = v;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       v;
  } vec_t;

  vec_t tbl[7];

  logic [9:0] exp_q[$];

  initial begin
    logic [7:0] rs;
    logic       rco;
    logic       rv;
    int         lat;
    bit         busy_ok;
    bit         stable_ok;
    logic [1:0] dbg0;
    logic [9:0] e;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s", s, 0);
    check("reset_co", co, 0);
    check("reset_v", v, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].ci, 0, rs, rco, rv, lat, busy_ok);
      check($sformatf("tbl%0d_s", i), rs, tbl[i].s);
      check($sformatf("tbl%0d_co", i), rco, tbl[i].co);
      check($sformatf("tbl%0d_v", i), rv, tbl[i].v);
      check($sformatf("tbl%0d_latency", i), lat, N);
      check($sformatf("tbl%0d_busy_not_ready", i), busy_ok, 1);
    end

    // Backpressure: result held for 10 cycles, new operands ignored
    in_valid = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, N);
    dbg0 = dbg;
    stable_ok = 1'b1;
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; ci = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (s !== 8'h46 || co !== 1'b0 || v !== 1'b0 || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || dbg !== dbg0) stable_ok = 1'b0;
    end
    check("bp_stable", stable_ok, 1);
    out_ready = 1'b1;
    check("bp_no_ready_in_done", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released_out_valid", out_valid, 0);
    check("bp_no_same_cycle_accept", in_ready, 1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_idle_stays_idle", out_valid, 0);

    // Reset pulse in the second BUSY cycle
    in_valid = 1'b1; a = 8'h55; b = 8'h22; ci = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_s", s, 0);
    check("rst_mid_co", co, 0);
    check("rst_mid_v", v, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_partial", out_valid, 0);
    run_op(8'h10, 8'h20, 1'b0, 0, rs, rco, rv, lat, busy_ok);
    check("after_rst_s", rs, 8'h30);
    check("after_rst_latency", lat, N);

    // Round trip: (A-B) + B gives A back
    for (int i = 0; i < 50; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(8'(ra - rb), rb, 1'b0, 0, rs, rco, rv, lat, busy_ok);
      check($sformatf("roundtrip%0d", i), rs, ra);
    end

    // Random operations against the reference model
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp_q.push_back(model8(ra, rb, rc));
      run_op(ra, rb, rc, $urandom_range(0, 2), rs, rco, rv, lat, busy_ok);
      e = exp_q.pop_front();
      check($sformatf("rand%0d", i), {rco, rv, rs}, e);
      check($sformatf("rand%0d_latency", i), lat, N);
    end

    for (int i = 0; i < 20000 && sw_done_cnt != 4; i++) @(posedge clk);
    check("sweep_done", sw_done_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Parameter sweep: digit in {1,4,8} at width 8, and digit 8 at width 32
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int SW = (g == 3) ? 32 : 8;
    localparam int SD = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    localparam int SN = SW / SD;

    logic          srst_n;
    logic          sin_valid;
    logic          sin_ready;
    logic          sout_valid;
    logic          sout_ready;
    logic          sci;
    logic          sco;
    logic          sv;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [SW-1:0] ss;
    logic [1:0]    sdbg;

    add_digit_serial #(.width(SW), .digit(SD)) u_sw (
      .clk_i       (clk),
      .rst_ni      (srst_n),
      .in_valid_i  (sin_valid),
      .in_ready_o  (sin_ready),
      .A           (sa),
      .B           (sb),
      .CI          (sci),
      .out_valid_o (sout_valid),
      .out_ready_i (sout_ready),
      .S           (ss),
      .CO          (sco),
      .V           (sv),
      .dbg_state_o (sdbg)
    );

    initial begin
      int              lat;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned full;
      longint          sgn;
      logic [SW-1:0]   es;
      logic            eco;
      logic            ev;

      srst_n = 1'b0; sin_valid = 1'b0; sout_ready = 1'b0; sa = '0; sb = '0; sci = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      srst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 150; k++) begin
        if (k == 0) begin
          sa = '1; sb = '0; sci = 1'b1;
        end else begin
          sa = SW'($urandom); sb = SW'($urandom); sci = 1'($urandom);
        end
        ua   = 64'(sa);
        ub   = 64'(sb);
        full = ua + ub + 64'(sci);
        es   = SW'(full);
        eco  = full[SW];
        sgn  = (sa[SW-1] ? longint'(ua) - (64'sd1 <<< SW) : longint'(ua)) +
               (sb[SW-1] ? longint'(ub) - (64'sd1 <<< SW) : longint'(ub)) + longint'(sci);
        ev   = (sgn > ((64'sd1 <<< (SW-1)) - 1)) || (sgn < -(64'sd1 <<< (SW-1)));
        check($sformatf("sweep_w%0d_d%0d_ready", SW, SD), sin_ready, 1);
        sin_valid = 1'b1;
        @(posedge clk); #1;
        sin_valid = 1'b0;
        lat = 0;
        while (!sout_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check($sformatf("sweep_w%0d_d%0d_latency", SW, SD), lat, SN);
        check($sformatf("sweep_w%0d_d%0d_s", SW, SD), ss, es);
        check($sformatf("sweep_w%0d_d%0d_co", SW, SD), sco, eco);
        check($sformatf("sweep_w%0d_d%0d_v", SW, SD), sv, ev);
        sout_ready = 1'b1;
        @(posedge clk); #1;
        sout_ready = 1'b0;
      end
      sw_done_cnt++;
    end
  end

endmodule
